fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
- Parametrised, pipelined floating-point compare/select unit: FEQ, FLT, FLE, FMIN, FMAX on IEEE-style operands of configurable exponent/mantissa width.
- Sits in the FPU as the compare lane, behind the issue stage, with valid/ready handshakes on both sides and a tag that passes through with each operation for writeback.
- Generalises the single-precision combinational less-than to multiple modes, arbitrary format and a stallable pipeline of configurable depth.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, mantissa width; operand width W = 1+EXP_W+MAN_W
- STAGES, 2, pipeline depth in registers, legal 1..4
- TAG_W, 5, width of the pass-through tag (e.g. rd index)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts this cycle
- op  in  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX; 5..7 reserved
- x1  in  W  operand 1
- x2  in  W  operand 2
- tag  in  TAG_W  pass-through tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- y  out  W  result: compare ops give {0..0, bit}; FMIN/FMAX give the selected operand
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset is asynchronous and active-low. One clock, clk; reset rstn. On reset all stage-valid bits are 0. out_valid=0, y=0, out_tag=0. Operations in flight are discarded. in_ready=1 one cycle after rstn deasserts.
- Transfer in: in_valid&&in_ready. Transfer out: out_valid&&out_ready.
- Pipeline: STAGES registered slots. Stage k advances when its successor is empty or advancing. The last stage advances on out_ready.
- in_ready = !valid[0] || stage 0 advancing, with no combinational path from in_valid.
- Full throughput: one op per cycle. Latency is exactly STAGES cycles, accept edge to out_valid, with no stall.
- Back-pressure: while out_valid && !out_ready, y and out_tag are held stable. Bubbles collapse. Full-pipe stall deasserts in_ready, and no data is lost or duplicated.
- Compute happens in the stage-0 input logic and is registered in slot 0. Later slots only delay the result.
- Field split: s=msb, em = lower W-1 bits.
- Magnitude-zero rule: if em1==0 && em2==0, the operands are equal for FEQ/FLT/FLE, so +0==-0.
- lt:
  - s1&!s2 -> 1
  - !s1&s2 -> 0
  - both positive -> em1<em2
  - both negative -> em1>em2
- eq: (x1==x2) || both zero.
- FEQ=eq, FLT=lt, FLE=lt||eq.
- FMIN returns x1 if lt else x2. FMAX returns x1 if !lt && !eq, else x2.
- Signed-zero ordering for min/max only: -0 < +0, so FMIN(+0,-0) = -0 and FMAX(+0,-0) = +0. When the operands are otherwise equal, either operand may be returned because they are bit-identical.
- Reserved op codes produce y=0 with a normal handshake.
- Reset mid-stall: the pipe empties and out_valid drops asynchronously.

Optional Feature:
- Macro FCMP_NAN_EN.
- Defined: NaN is exp all-ones with mantissa !=0.
  - Any NaN operand makes FEQ/FLT/FLE return 0.
  - FMIN/FMAX return the non-NaN operand.
  - If both operands are NaN, the result is canonical qNaN: {0, all-ones exp, 1, 0..0}.
- Undefined: NaN patterns are compared as ordinary sign-magnitude bit patterns by the rules above, with no extra logic.

Test Plan:
- FLT 0x3F800000 (1.0) vs 0x40000000 (2.0), tag 3, STAGES=2 -> out_valid exactly 2 cycles later, y=1, out_tag=3. Swapped operands -> y=0.
- FLT 0xBF800000 (-1.0) vs 0xC0000000 (-2.0) -> y=0. FLE 0x80000000 vs 0x00000000 -> y=1. FEQ on the same pair -> y=1. FLT on the same pair -> y=0.
- FMIN(0x00000000, 0x80000000) -> y=0x80000000. FMAX on the same pair -> y=0x00000000. FMAX(1.0, -2.0) -> 0x3F800000.
- Stream 8 back-to-back ops with out_ready held 0 for 5 cycles mid-stream -> in_ready drops once the pipe is full. All 8 results emerge in order, with tags 0..7, no duplicates, and y stable during the stall.
- Assert rstn low with 2 ops in flight -> out_valid=0 and y=0 immediately. After release the pipe is empty and the next op completes with normal latency.
- With FCMP_NAN_EN:
  - FLT(0x7FC00000, 1.0) -> 0.
  - FMIN(0x7FC00000, 1.0) -> 0x3F800000.
  - FMAX(NaN, NaN) -> 0x7FC00000.
- Without FCMP_NAN_EN: FLT(0x7FC00000, 0x7F800000) -> 0.

Source files
------------

// File: rtl/fcmp_pipe_if.sv
// Handshake and operand bundle for the fcmp_pipe compare lane.
// The master side issues operations and consumes results; the slave side is the unit.
interface fcmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     x1;
  logic [W-1:0]     x2;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op, x1, x2, tag, out_ready,
    input  in_ready, out_valid, y, out_tag
  );

  modport slave (
    input  in_valid, op, x1, x2, tag, out_ready,
    output in_ready, out_valid, y, out_tag
  );
endinterface

// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare/select lane (FEQ/FLT/FLE/FMIN/FMAX) with tag pass-through.
// Define FCMP_NAN_EN to give NaN operands IEEE-style unordered/quiet handling.
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic       clk,
  input logic       rstn,
  fcmp_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } op_e;

  logic         s1, s2;
  logic [W-2:0] em1, em2;
  logic         both_zero, eq_bits, lt_raw, lt_cmp, eq_cmp;
  logic [W-1:0] res;

  assign s1  = bus.x1[W-1];
  assign s2  = bus.x2[W-1];
  assign em1 = bus.x1[W-2:0];
  assign em2 = bus.x2[W-2:0];

  assign both_zero = (em1 == '0) && (em2 == '0);
  assign eq_bits   = (bus.x1 == bus.x2);

  // lt_raw orders -0 below +0, which is what min/max want; the compare ops mask that out.
  always_comb begin
    lt_raw = 1'b0;
    case ({s1, s2})
      2'b10:   lt_raw = 1'b1;
      2'b01:   lt_raw = 1'b0;
      2'b00:   lt_raw = (em1 < em2);
      default: lt_raw = (em1 > em2);
    endcase
  end

  assign lt_cmp = lt_raw && !both_zero;
  assign eq_cmp = eq_bits || both_zero;

`ifdef FCMP_NAN_EN
  localparam logic [W-1:0] QNAN = (W'({EXP_W{1'b1}}) << MAN_W) | (W'(1) << (MAN_W - 1));

  logic nan1, nan2;
  assign nan1 = (&bus.x1[W-2:MAN_W]) && (|bus.x1[MAN_W-1:0]);
  assign nan2 = (&bus.x2[W-2:MAN_W]) && (|bus.x2[MAN_W-1:0]);
`endif

  always_comb begin
    res = '0;
    case (op_e'(bus.op))
      OP_FEQ:  res[0] = eq_cmp;
      OP_FLT:  res[0] = lt_cmp;
      OP_FLE:  res[0] = lt_cmp || eq_cmp;
      OP_FMIN: res = lt_raw ? bus.x1 : bus.x2;
      OP_FMAX: res = (!lt_raw && !eq_bits) ? bus.x1 : bus.x2;
      default: res = '0;
    endcase
`ifdef FCMP_NAN_EN
    if (nan1 || nan2) begin
      case (op_e'(bus.op))
        OP_FEQ, OP_FLT, OP_FLE: res = '0;
        OP_FMIN, OP_FMAX:       res = (nan1 && nan2) ? QNAN : (nan1 ? bus.x2 : bus.x1);
        default:                res = '0;
      endcase
    end
`endif
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] free;
  logic [W-1:0]      y_q   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];

  // A slot can take new data unless it and every slot after it are full while the sink stalls.
  always_comb begin
    logic all_full;
    free     = '0;
    all_full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full && valid_q[k];
      free[k]  = !all_full || bus.out_ready;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      if (free[0]) begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          y_q[0]   <= res;
          tag_q[0] <= bus.tag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (free[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            y_q[k]   <= y_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = free[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.y         = y_q[STAGES-1];
  assign bus.out_tag   = tag_q[STAGES-1];
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed IEEE corner cases, stalled and random streams, and reset in flight.
// Expected results come from an ordered-key reference model; NaN cases follow FCMP_NAN_EN.
module tb_fcmp_pipe;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int W      = 1 + EXP_W + MAN_W;

  localparam logic [2:0] FEQ = 3'd0, FLT = 3'd1, FLE = 3'd2, FMIN = 3'd3, FMAX = 3'd4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fcmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fcmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [2:0]       s_op [64];
  logic [W-1:0]     s_a  [64];
  logic [W-1:0]     s_b  [64];
  logic [W-1:0]     exp_y   [$];
  logic [TAG_W-1:0] exp_tag [$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Sign-magnitude maps onto integers; cmp_key merges the zeros, ord_key puts -0 just below +0.
  function automatic longint cmp_key(input logic [W-1:0] v);
    longint m = longint'(v[W-2:0]);
    return v[W-1] ? -m : m;
  endfunction

  function automatic longint ord_key(input logic [W-1:0] v);
    longint m = longint'(v[W-2:0]);
    return v[W-1] ? (-m - 1) : m;
  endfunction

`ifdef FCMP_NAN_EN
  function automatic bit is_nan(input logic [W-1:0] v);
    return (v[W-2:MAN_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction
`endif

  function automatic logic [W-1:0] ref_y(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r = '0;
`ifdef FCMP_NAN_EN
    if (is_nan(a) || is_nan(b)) begin
      if (o == FMIN || o == FMAX)
        r = (is_nan(a) && is_nan(b)) ? 32'h7FC00000 : (is_nan(a) ? b : a);
      return r;
    end
`endif
    case (o)
      FEQ:     r = W'(cmp_key(a) == cmp_key(b));
      FLT:     r = W'(cmp_key(a) <  cmp_key(b));
      FLE:     r = W'(cmp_key(a) <= cmp_key(b));
      FMIN:    r = (ord_key(a) < ord_key(b)) ? a : b;
      FMAX:    r = (ord_key(a) > ord_key(b)) ? a : b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand(input logic [W-1:0] other);
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'h00000000;
      1:       v = 32'h80000000;
      2:       v = other;
      3:       v = other ^ 32'h80000000;
      4:       v = 32'h7FC00000 | (W'($urandom_range(0, 1)) << (W - 1));
      5:       v = 32'h7F800000;
      6:       v = 32'h3F800000 | W'($urandom_range(0, 3));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Called just after a rising edge with an empty pipe; measures latency and checks the result.
  task automatic apply_stimulus(input string name, input logic [2:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [TAG_W-1:0] t, input logic [W-1:0] ey);
    int lat;
    bus.op        = o;
    bus.x1        = a;
    bus.x2        = b;
    bus.tag       = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(STAGES));
    check({name, "_y"}, 64'(bus.y), 64'(ey));
    check({name, "_tag"}, 64'(bus.out_tag), 64'(t));
    @(posedge clk); #1;
  endtask

  // Streams s_op/s_a/s_b[0..n-1] with tags 0..n-1, optional forced stall window and random gaps/back-pressure.
  task automatic check_output(input string name, input int n, input int stall_from, input int stall_len, input bit rand_bp);
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    bit pend = 1'b0;
    bit held = 1'b0;
    bit saw_block = 1'b0;
    logic [W-1:0]     hy = '0;
    logic [TAG_W-1:0] ht = '0;
    exp_y.delete();
    exp_tag.delete();
    while (recv < n && cyc < 2000) begin
      bus.in_valid = (sent < n) && (pend || !rand_bp || ($urandom_range(0, 2) != 0));
      pend = bus.in_valid;
      if (sent < n) begin
        bus.op  = s_op[sent];
        bus.x1  = s_a[sent];
        bus.x2  = s_b[sent];
        bus.tag = TAG_W'(sent);
      end
      if (cyc >= stall_from && cyc < stall_from + stall_len) bus.out_ready = 1'b0;
      else bus.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (held) begin
        check({name, "_hold_y"}, 64'(bus.y), 64'(hy));
        check({name, "_hold_tag"}, 64'(bus.out_tag), 64'(ht));
      end
      held = bus.out_valid && !bus.out_ready;
      hy   = bus.y;
      ht   = bus.out_tag;
      if (!bus.in_ready) saw_block = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        check({name, "_expected_pending"}, 64'(exp_y.size() != 0), 64'd1);
        if (exp_y.size() != 0) begin
          check({name, "_y"}, 64'(bus.y), 64'(exp_y.pop_front()));
          check({name, "_tag"}, 64'(bus.out_tag), 64'(exp_tag.pop_front()));
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_y.push_back(ref_y(s_op[sent], s_a[sent], s_b[sent]));
        exp_tag.push_back(TAG_W'(sent));
        sent++;
        pend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({name, "_received"}, 64'(recv), 64'(n));
    check({name, "_sent"}, 64'(sent), 64'(n));
    if (stall_len > 0) check({name, "_in_ready_dropped"}, 64'(saw_block), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.x1        = '0;
    bus.x2        = '0;
    bus.tag       = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_y", 64'(bus.y), 64'd0);
    check("reset_out_tag", 64'(bus.out_tag), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    apply_stimulus("flt_1_2",      FLT,  32'h3F800000, 32'h40000000, 5'd3, 32'h1);
    apply_stimulus("flt_2_1",      FLT,  32'h40000000, 32'h3F800000, 5'd4, 32'h0);
    apply_stimulus("flt_m1_m2",    FLT,  32'hBF800000, 32'hC0000000, 5'd5, 32'h0);
    apply_stimulus("fle_mz_pz",    FLE,  32'h80000000, 32'h00000000, 5'd6, 32'h1);
    apply_stimulus("feq_mz_pz",    FEQ,  32'h80000000, 32'h00000000, 5'd7, 32'h1);
    apply_stimulus("flt_mz_pz",    FLT,  32'h80000000, 32'h00000000, 5'd8, 32'h0);
    apply_stimulus("feq_1_2",      FEQ,  32'h3F800000, 32'h40000000, 5'd9, 32'h0);
    apply_stimulus("fmin_pz_mz",   FMIN, 32'h00000000, 32'h80000000, 5'd10, 32'h80000000);
    apply_stimulus("fmax_pz_mz",   FMAX, 32'h00000000, 32'h80000000, 5'd11, 32'h00000000);
    apply_stimulus("fmax_1_m2",    FMAX, 32'h3F800000, 32'hC0000000, 5'd12, 32'h3F800000);
    apply_stimulus("fmin_m2_1",    FMIN, 32'hC0000000, 32'h3F800000, 5'd13, 32'hC0000000);
    apply_stimulus("reserved_op6", 3'd6, 32'h3F800000, 32'h40000000, 5'd14, 32'h0);
`ifdef FCMP_NAN_EN
    apply_stimulus("nan_flt",      FLT,  32'h7FC00000, 32'h3F800000, 5'd15, 32'h0);
    apply_stimulus("nan_fmin",     FMIN, 32'h7FC00000, 32'h3F800000, 5'd16, 32'h3F800000);
    apply_stimulus("nan_fmax_both", FMAX, 32'h7FC00000, 32'hFFC00001, 5'd17, 32'h7FC00000);
`else
    apply_stimulus("nonan_flt",    FLT,  32'h7FC00000, 32'h7F800000, 5'd15, 32'h0);
`endif

    for (int i = 0; i < 8; i++) begin
      s_op[i] = 3'($urandom_range(0, 4));
      s_a[i]  = W'($urandom);
      s_b[i]  = rand_operand(s_a[i]);
    end
    check_output("stall", 8, 3, 5, 1'b0);

    for (int i = 0; i < 48; i++) begin
      s_op[i] = 3'($urandom_range(0, 7));
      s_a[i]  = rand_operand(W'($urandom));
      s_b[i]  = rand_operand(s_a[i]);
    end
    check_output("random", 48, 0, 0, 1'b1);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = FLT;
    bus.x1        = 32'h3F800000;
    bus.x2        = 32'h40000000;
    bus.tag       = 5'd9;
    @(posedge clk); #1;
    bus.tag = 5'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flight_out_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_y", 64'(bus.y), 64'd0);
    check("midreset_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_empty", 64'(bus.out_valid), 64'd0);
    apply_stimulus("post_reset_fle", FLE, 32'h40000000, 32'h3F800000, 5'd21, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
